// File: rtl/y86_instr_encoder.sv
// y86_instr_encoder: serialises one decoded Y86-64 instruction into its byte encoding,
// one byte per out_valid/out_ready handshake, with a running byte address.
module y86_instr_encoder #(
    parameter logic [63:0] BASE_ADDR = 64'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  icode,
    input  logic [3:0]  ifun,
    input  logic [3:0]  rA,
    input  logic [3:0]  rB,
    input  logic [63:0] valC,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_byte,
    output logic [63:0] out_addr,
    output logic        out_last,
    output logic        err
);
    typedef enum logic {IDLE, SEND} state_t;
    state_t state;
    logic [3:0] ic, fn, ra, rb, len, idx, vidx, in_len;
    logic [63:0] vc, vsh;
    logic has_reg;
    function automatic logic [3:0] len_of(input logic [3:0] c);
        case (c)
            4'h0, 4'h1, 4'h9:         len_of = 4'd1;
            4'h2, 4'h6, 4'hA, 4'hB:   len_of = 4'd2;
            4'h7, 4'h8:               len_of = 4'd9;
            4'h3, 4'h4, 4'h5:         len_of = 4'd10;
            default:                  len_of = 4'd0;
        endcase
    endfunction
    assign in_len    = len_of(icode);
    assign in_ready  = state == IDLE;
    assign out_valid = state == SEND;
    assign out_last  = out_valid && idx == len - 4'd1;
    assign has_reg   = len == 4'd2 || len == 4'd10;
    // valC bytes start right after b0, or after the register byte when one exists
    assign vidx      = idx - (has_reg ? 4'd2 : 4'd1);
    always_comb begin
        vsh      = vc >> {vidx, 3'b000};
        out_byte = state == IDLE ? 8'h00 : idx == 4'd0 ? {ic, fn} : (has_reg && idx == 4'd1) ? {ra, rb} : vsh[7:0];
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            out_addr <= BASE_ADDR;
            err      <= 1'b0;
            ic       <= 4'h0;
            fn       <= 4'h0;
            ra       <= 4'h0;
            rb       <= 4'h0;
            vc       <= 64'h0;
            len      <= 4'h0;
            idx      <= 4'h0;
        end else begin
            err <= 1'b0;
            if (state == IDLE) begin
                if (in_valid) begin
                    if (in_len == 4'd0) begin
                        err <= 1'b1;
                    end else begin
                        state <= SEND;
                        ic    <= icode;
                        fn    <= ifun;
                        ra    <= icode == 4'h3 ? 4'hF : rA;
                        rb    <= (icode == 4'hA || icode == 4'hB) ? 4'hF : rB;
                        vc    <= valC;
                        len   <= in_len;
                        idx   <= 4'h0;
                    end
                end
            end else if (out_ready) begin
                out_addr <= out_addr + 64'd1;
                idx      <= idx + 4'd1;
                if (out_last) state <= IDLE;
            end
        end
    end
endmodule

// File: tb/tb_y86_instr_encoder.sv
// tb_y86_instr_encoder: random and directed instructions checked against a byte-list model.
module tb_y86_instr_encoder;
    localparam logic [63:0] BASE = 64'hFFFF_FFFF_FFFF_FFFA;
    logic clk = 0, rst = 1, in_valid = 0, in_ready, out_valid, out_ready = 1, out_last, err;
    logic [3:0] icode = 0, ifun = 0, rA = 0, rB = 0;
    logic [63:0] valC = 0, out_addr;
    logic [7:0] out_byte;
    y86_instr_encoder #(.BASE_ADDR(BASE)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .icode(icode), .ifun(ifun), .rA(rA), .rB(rB), .valC(valC),
        .out_valid(out_valid), .out_ready(out_ready), .out_byte(out_byte),
        .out_addr(out_addr), .out_last(out_last), .err(err)
    );
    always #5 clk = ~clk;
    typedef struct {logic [7:0] b; logic l;} ent_t;
    typedef struct {logic [63:0] a; logic [7:0] b; logic l;} rec_t;
    ent_t q[$];
    rec_t got[$];
    int len_tab[16] = '{1, 1, 2, 10, 10, 10, 2, 9, 9, 1, 2, 2, 0, 0, 0, 0};
    int total = 0, bad = 0, xfers = 0, rdy_mode = 1, pat = 0;
    logic [63:0] exp_addr = BASE;
    logic exp_err = 0;
    task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s got=%h exp=%h at %0t", n, a, e, $time);
        end
    endtask
    // expected encoding as a plain list of bytes built from the instruction format
    task automatic model_push(input logic [3:0] c, f, a, b, input logic [63:0] v);
        logic [7:0] bl[$];
        int L = len_tab[c];
        if (L == 0) return;
        bl.push_back({c, f});
        if (L == 2 || L == 10) bl.push_back({c == 4'h3 ? 4'hF : a, (c == 4'hA || c == 4'hB) ? 4'hF : b});
        if (L >= 9) for (int k = 0; k < 8; k++) bl.push_back(v[8*k +: 8]);
        for (int i = 0; i < bl.size(); i++) q.push_back('{b: bl[i], l: i == bl.size() - 1});
    endtask
    always @(negedge clk) begin
        chk("out_valid", out_valid, q.size() != 0);
        chk("in_ready", in_ready, q.size() == 0);
        chk("err", err, exp_err);
        if (out_valid && q.size() != 0) begin
            chk("out_byte", out_byte, q[0].b);
            chk("out_last", out_last, q[0].l);
            chk("out_addr", out_addr, exp_addr);
            if (out_ready) begin
                got.push_back('{a: out_addr, b: out_byte, l: out_last});
                void'(q.pop_front());
                exp_addr = exp_addr + 64'd1;
                xfers++;
            end
        end
    end
    initial forever begin
        @(posedge clk); #1;
        pat++;
        out_ready = rdy_mode == 1 ? 1'b1 : rdy_mode == 2 ? (pat % 3 == 0) : ($urandom_range(0, 3) != 0);
    end
    task automatic send(input logic [3:0] c, f, a, b, input logic [63:0] v);
        int n = 0;
        while (!in_ready && n < 300) begin
            in_valid = 1'($urandom_range(0, 1));
            icode = 4'($urandom); ifun = 4'($urandom); rA = 4'($urandom); rB = 4'($urandom);
            valC = {$urandom, $urandom};
            @(posedge clk); #1;
            n++;
        end
        chk("in_ready_wait", in_ready, 1);
        icode = c; ifun = f; rA = a; rB = b; valC = v; in_valid = 1;
        @(posedge clk); #1;
        in_valid = 0;
        model_push(c, f, a, b, v);
        if (len_tab[c] == 0) begin
            exp_err = 1;
            @(posedge clk); #1;
            exp_err = 0;
        end
    endtask
    task automatic wait_idle();
        int n = 0;
        while ((q.size() != 0 || !in_ready) && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        chk("idle_wait", q.size() == 0 && in_ready, 1);
    endtask
    task automatic do_reset();
        rst = 1;
        q.delete();
        exp_addr = BASE;
        exp_err = 0;
        @(posedge clk); #1;
        rst = 0;
    endtask
    logic [7:0] irm[10] = '{8'h30, 8'hF2, 8'hEF, 8'hCD, 8'hAB, 8'h89, 8'h67, 8'h45, 8'h23, 8'h01};
    logic [7:0] jx[11] = '{8'h73, 8'h40, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h60, 8'h12};
    initial begin
        logic [63:0] a0;
        int x0;
        @(posedge clk); #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_byte", out_byte, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_err", err, 0);
        chk("rst_out_addr", out_addr, BASE);
        rst = 0;
        got.delete();
        send(4'h0, 4'h0, 4'h0, 4'h0, 64'h0);
        wait_idle();
        chk("halt_count", got.size(), 1);
        if (got.size() == 1) begin
            chk("halt_byte", got[0].b, 8'h00);
            chk("halt_last", got[0].l, 1);
            chk("halt_addr", got[0].a, BASE);
        end
        got.delete();
        send(4'h3, 4'h0, 4'h0, 4'h2, 64'h0123456789ABCDEF);
        wait_idle();
        chk("irmovq_count", got.size(), 10);
        for (int i = 0; i < 10 && i < got.size(); i++) begin
            chk("irmovq_byte", got[i].b, irm[i]);
            chk("irmovq_addr", got[i].a, BASE + 64'd1 + 64'(i));
            chk("irmovq_last", got[i].l, i == 9);
        end
        do_reset();
        got.delete();
        send(4'h7, 4'h3, 4'h5, 4'h6, 64'h40);
        send(4'h6, 4'h0, 4'h1, 4'h2, 64'h0);
        wait_idle();
        chk("jxx_count", got.size(), 11);
        for (int i = 0; i < 11 && i < got.size(); i++) begin
            chk("jxx_byte", got[i].b, jx[i]);
            chk("jxx_addr", got[i].a, BASE + 64'(i));
            chk("jxx_last", got[i].l, i == 8 || i == 10);
        end
        rdy_mode = 2;
        got.delete();
        send(4'h4, 4'h0, 4'h3, 4'h4, 64'h1122334455667788);
        wait_idle();
        chk("bp_count", got.size(), 10);
        if (got.size() == 10) begin
            chk("bp_b0", got[0].b, 8'h40);
            chk("bp_b1", got[1].b, 8'h34);
            chk("bp_b9", got[9].b, 8'h11);
            chk("bp_addr9", got[9].a, BASE + 64'd20);
        end
        rdy_mode = 1;
        a0 = out_addr;
        send(4'hD, 4'h0, 4'h0, 4'h0, 64'h0);
        chk("inv_addr", out_addr, a0);
        rdy_mode = 0;
        x0 = xfers;
        send(4'h8, 4'h0, 4'h0, 4'h0, 64'hDEADBEEF00C0FFEE);
        for (int n = 0; n < 200 && xfers < x0 + 4; n++) begin @(posedge clk); #1; end
        chk("call_four_bytes", xfers - x0, 4);
        @(posedge clk); #1;
        rst = 1;
        q.delete();
        exp_addr = BASE;
        #1;
        chk("abort_out_valid", out_valid, 0);
        chk("abort_out_addr", out_addr, BASE);
        chk("abort_in_ready", in_ready, 1);
        @(posedge clk); #1;
        rst = 0;
        got.delete();
        send(4'h0, 4'h0, 4'h0, 4'h0, 64'h0);
        wait_idle();
        chk("post_abort_count", got.size(), 1);
        if (got.size() == 1) chk("post_abort_addr", got[0].a, BASE);
        repeat (300) begin
            send(4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom), {$urandom, $urandom});
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) begin
                icode = 4'($urandom); valC = {$urandom, $urandom};
                @(posedge clk); #1;
            end
        end
        wait_idle();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
